// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Loadable down-counter. Counts qualified enable ticks from a programmed value
// down to zero, then spends exactly one cycle in EXPIRE where it pulses
// `expire` and sets the sticky `irq` flag. In periodic mode the counter is
// reloaded from the reload register and counting continues; in one-shot mode
// the timer returns to IDLE holding zero.
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous reset, active-low, overrides every other input
//   enable      count tick qualifier (one decrement per high cycle in RUN)
//   load        capture load_value into the reload register and the counter
//   load_value  value captured by load
//   start       begin / resume counting (ignored when counter is zero)
//   stop        pause counting, counter is held
//   periodic    1 = auto-reload at terminal count, 0 = one-shot
//   irq_ack     clears irq (loses against a simultaneous set)
//   counter     current count
//   expire      one-cycle terminal-count pulse
//   irq         sticky terminal-count flag
//   busy        high whenever the timer is not IDLE
//
// Input priority, highest first: reset > load > stop > start > enable.
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] counter,
  output logic             expire,
  output logic             irq,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic             term_tick;

  // The tick that takes the counter from 1 to 0. It is the only event that
  // sets irq on its way into EXPIRE, so irq becomes visible in the same cycle
  // as expire. A load or stop on the same edge cancels it.
  assign term_tick = !load && (state == RUN) && !stop && enable && (counter == ONE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      counter  <= ZERO;
      reload_q <= ZERO;
      state    <= IDLE;
      irq      <= 1'b0;
    end else begin
      if (load) begin
        // Load abandons whatever was in flight, including a pending EXPIRE.
        reload_q <= load_value;
        counter  <= load_value;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // stop outranks start, so start+stop together stays idle.
            if (!stop && start && (counter != ZERO)) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
            end else if (enable) begin
              if (counter == ONE) begin
                counter <= ZERO;
                state   <= EXPIRE;
              end else if (counter != ZERO) begin
                counter <= counter - ONE;
              end
            end
          end
          EXPIRE: begin
            // enable is deliberately ignored here: the EXPIRE cycle is part
            // of the period and never consumes a tick.
            if (periodic && (reload_q != ZERO) && !stop) begin
              counter <= reload_q;
              state   <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end

      // Set wins over acknowledge. While in EXPIRE irq is already high and
      // an acknowledge sampled at the end of that cycle is not honoured.
      if (term_tick || (state == EXPIRE)) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

  // Pure decodes of the state register: no input reaches these outputs.
  assign expire = (state == EXPIRE);
  assign busy   = (state != IDLE);

endmodule
